// File: rtl/si570_config_sequencer.sv
// Drives i2c_master through the fixed Si570 reprogramming sequence:
// mux select, freeze DCO, regs 7..12, unfreeze, NewFreq, then poll NewFreq until it clears.
module si570_config_sequencer #(
    parameter logic [6:0]  MuxAddress   = 7'h74,
    parameter logic [7:0]  MuxChannel   = 8'h01,
    parameter logic [6:0]  Si570Address = 7'h5D,
    parameter int unsigned MaxPolls     = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [47:0] i_freq_regs,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [2:0]  o_step,
    output logic        o_rv0_valid,
    input  logic        i_rv0_ready,
    output logic [6:0]  o_rv0_slave_address,
    output logic [31:0] o_rv0_wdata,
    output logic [1:0]  o_rv0_burst_count_wr,
    output logic [1:0]  o_rv0_burst_count_rd,
    output logic        o_rv0_rd_wrn,
    input  logic        i_rv1_valid,
    output logic        o_rv1_ready,
    input  logic [31:0] i_rv1_rdata
);

    typedef enum logic [2:0] {StIdle, StIssue, StWaitResp, StDone, StError} state_e;

    localparam logic [7:0] MaxPollsCnt = 8'(MaxPolls);
    localparam logic [2:0] PollStep    = 3'd6;

    state_e      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  poll_q, poll_d;
    logic [47:0] regs_q, regs_d;
    logic        error_q, error_d;

    // Only the NewFreq bit of a poll response matters.
    logic unused_rdata;
    assign unused_rdata = ^{i_rv1_rdata[31:7], i_rv1_rdata[5:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            step_q  <= 3'd0;
            poll_q  <= 8'd0;
            regs_q  <= 48'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            poll_q  <= poll_d;
            regs_q  <= regs_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        poll_d  = poll_q;
        regs_d  = regs_q;
        error_d = error_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    regs_d  = i_freq_regs;
                    error_d = 1'b0;
                    poll_d  = 8'd0;
                    step_d  = 3'd0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (i_rv0_ready) state_d = StWaitResp;
            end
            StWaitResp: begin
                if (i_rv1_valid) begin
                    if (step_q != PollStep) begin
                        step_d  = step_q + 3'd1;
                        state_d = StIssue;
                    end else if (!i_rv1_rdata[6]) begin
                        state_d = StDone;
                    end else begin
                        poll_d = poll_q + 8'd1;
                        if (poll_d == MaxPollsCnt) begin
                            error_d = 1'b1;
                            state_d = StError;
                        end else begin
                            state_d = StIssue;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request fields are forced to zero outside ISSUE so idle outputs stay quiet.
    always_comb begin
        o_busy               = (state_q == StIssue) || (state_q == StWaitResp);
        o_done               = (state_q == StDone);
        o_error              = error_q;
        o_step               = step_q;
        o_rv0_valid          = (state_q == StIssue);
        o_rv1_ready          = (state_q == StWaitResp);
        o_rv0_slave_address  = 7'd0;
        o_rv0_wdata          = 32'd0;
        o_rv0_burst_count_wr = 2'd0;
        o_rv0_burst_count_rd = 2'd0;
        o_rv0_rd_wrn         = 1'b0;
        if (state_q == StIssue) begin
            o_rv0_slave_address = Si570Address;
            unique case (step_q)
                3'd0: begin
                    o_rv0_slave_address = MuxAddress;
                    o_rv0_wdata         = {24'd0, MuxChannel};
                end
                3'd1: begin
                    o_rv0_wdata          = 32'h0000_1089;
                    o_rv0_burst_count_wr = 2'd1;
                end
                3'd2: begin
                    o_rv0_wdata          = {regs_q[31:24], regs_q[39:32], regs_q[47:40], 8'd7};
                    o_rv0_burst_count_wr = 2'd3;
                end
                3'd3: begin
                    o_rv0_wdata          = {regs_q[7:0], regs_q[15:8], regs_q[23:16], 8'd10};
                    o_rv0_burst_count_wr = 2'd3;
                end
                3'd4: begin
                    o_rv0_wdata          = 32'h0000_0089;
                    o_rv0_burst_count_wr = 2'd1;
                end
                3'd5: begin
                    o_rv0_wdata          = 32'h0000_4087;
                    o_rv0_burst_count_wr = 2'd1;
                end
                3'd6: begin
                    o_rv0_wdata  = 32'h0000_0087;
                    o_rv0_rd_wrn = 1'b1;
                end
                default: o_rv0_wdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_si570_config_sequencer.sv
// Directed bench for si570_config_sequencer with a fixed-latency i2c_master responder.
module tb_si570_config_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [47:0] freq_regs;
    logic        busy, done, error;
    logic [2:0]  step;
    logic        rv0_valid, rv0_ready;
    logic [6:0]  rv0_addr;
    logic [31:0] rv0_wdata;
    logic [1:0]  rv0_wr, rv0_rd;
    logic        rv0_rd_wrn;
    logic        rv1_valid, rv1_ready;
    logic [31:0] rv1_rdata;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int poll_ones = 0;  // -1: every poll reports NewFreq still set

    logic [6:0]  lg_addr[$];
    logic [31:0] lg_wdata[$];
    logic [1:0]  lg_wr[$];
    logic [1:0]  lg_rd[$];
    logic        lg_rdwrn[$];

    logic [6:0]  exp_addr[7]  = '{7'h74, 7'h5D, 7'h5D, 7'h5D, 7'h5D, 7'h5D, 7'h5D};
    logic [31:0] exp_wdata[7] = '{32'h0000_0001, 32'h0000_1089, 32'hBCC2_0107,
                                  32'hB81E_010A, 32'h0000_0089, 32'h0000_4087, 32'h0000_0087};
    logic [1:0]  exp_wr[7]    = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1, 2'd0};
    logic        exp_rdwrn[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    si570_config_sequencer #(.MaxPolls(3)) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_start              (start),
        .i_freq_regs          (freq_regs),
        .o_busy               (busy),
        .o_done               (done),
        .o_error              (error),
        .o_step               (step),
        .o_rv0_valid          (rv0_valid),
        .i_rv0_ready          (rv0_ready),
        .o_rv0_slave_address  (rv0_addr),
        .o_rv0_wdata          (rv0_wdata),
        .o_rv0_burst_count_wr (rv0_wr),
        .o_rv0_burst_count_rd (rv0_rd),
        .o_rv0_rd_wrn         (rv0_rd_wrn),
        .i_rv1_valid          (rv1_valid),
        .o_rv1_ready          (rv1_ready),
        .i_rv1_rdata          (rv1_rdata)
    );

    always #5 clk = ~clk;

    // Responder: logs each accepted request, answers 3 cycles later.
    initial begin
        int  delay;
        int  ones_given;
        logic is_poll;
        delay = 0;
        ones_given = 0;
        is_poll = 1'b0;
        rv1_valid = 1'b0;
        rv1_rdata = 32'd0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                rv1_valid = 1'b0;
                delay = 0;
            end else begin
                if (rv1_valid) rv1_valid = 1'b0;
                if (rv0_valid && rv0_ready) begin
                    lg_addr.push_back(rv0_addr);
                    lg_wdata.push_back(rv0_wdata);
                    lg_wr.push_back(rv0_wr);
                    lg_rd.push_back(rv0_rd);
                    lg_rdwrn.push_back(rv0_rd_wrn);
                    if (rv0_addr == 7'h74) ones_given = 0;
                    is_poll = rv0_rd_wrn;
                    delay = 3;
                end else if (delay > 0) begin
                    delay--;
                    if (delay == 0) begin
                        rv1_valid = 1'b1;
                        rv1_rdata = 32'hFFFF_FFFF;  // write beats carry junk that must be ignored
                        if (is_poll) begin
                            rv1_rdata = 32'h0000_0000;
                            if (poll_ones < 0 || ones_given < poll_ones) begin
                                rv1_rdata = 32'h0000_0040;
                                ones_given++;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (done) done_cnt++;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_to_end(input int budget, output bit got_done, output bit got_err,
                              output int busy_low, output bit busy_at_end);
        got_done = 1'b0;
        got_err = 1'b0;
        busy_low = 0;
        busy_at_end = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                busy_at_end = busy;
                break;
            end
            if (error && !busy) begin
                got_err = 1'b1;
                busy_at_end = busy;
                break;
            end
            if (!busy) busy_low++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, rv0_valid, rv1_ready} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000", {busy, done, error, rv0_valid, rv1_ready});
        end
        checks++;
        if (step !== 3'd0) begin
            failures++;
            $display("FAIL reset_step got=%0d want=0", step);
        end
        checks++;
        if ({rv0_addr, rv0_wdata, rv0_wr, rv0_rd, rv0_rd_wrn} !== 44'd0) begin
            failures++;
            $display("FAIL reset_rv0 addr=%h wdata=%h want all zero", rv0_addr, rv0_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_sequence();
        int base, n, d0, bl;
        bit gd, ge, be;
        base = lg_addr.size();
        d0 = done_cnt;
        poll_ones = 0;
        pulse_start();
        run_to_end(300, gd, ge, bl, be);
        n = lg_addr.size() - base;
        checks++;
        if (gd !== 1'b1 || n != 7) begin
            failures++;
            $display("FAIL seq_count done=%b requests=%0d want done=1 requests=7", gd, n);
        end
        if (n > 7) n = 7;
        for (int k = 0; k < n; k++) begin
            checks++;
            if ({lg_addr[base+k], lg_wdata[base+k], lg_wr[base+k], lg_rd[base+k],
                 lg_rdwrn[base+k]} !== {exp_addr[k], exp_wdata[k], exp_wr[k], 2'd0, exp_rdwrn[k]}) begin
                failures++;
                $display("FAIL seq_step%0d got addr=%h wdata=%h wr=%0d rd=%0d rdwrn=%b want addr=%h wdata=%h wr=%0d rd=0 rdwrn=%b",
                         k, lg_addr[base+k], lg_wdata[base+k], lg_wr[base+k], lg_rd[base+k],
                         lg_rdwrn[base+k], exp_addr[k], exp_wdata[k], exp_wr[k], exp_rdwrn[k]);
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL seq_done_pulses got=%0d want=1", done_cnt - d0);
        end
        checks++;
        if (bl != 0 || be !== 1'b0) begin
            failures++;
            $display("FAIL seq_busy low_cycles=%0d busy_on_done=%b want 0 and 0", bl, be);
        end
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL seq_error got=%b want=0", error);
        end
    endtask

    task automatic test_ready_stall();
        int base, n, d0, bl;
        bit gd, ge, be, seen;
        base = lg_addr.size();
        d0 = done_cnt;
        seen = 1'b0;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rv1_ready && step == 3'd1) begin
                rv0_ready = 1'b0;
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL stall_reach_step1 got=0 want=1");
        end
        while (!rv0_valid && seen) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({rv0_valid, step, rv0_addr, rv0_wdata, rv0_wr, rv0_rd, rv0_rd_wrn} !==
                {1'b1, 3'd2, 7'h5D, 32'hBCC2_0107, 2'd3, 2'd0, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d valid=%b step=%0d addr=%h wdata=%h wr=%0d want 1 2 5d bcc20107 3",
                         i, rv0_valid, step, rv0_addr, rv0_wdata, rv0_wr);
            end
            @(negedge clk);
        end
        checks++;
        if (lg_addr.size() - base != 2) begin
            failures++;
            $display("FAIL stall_no_handshake requests=%0d want=2", lg_addr.size() - base);
        end
        rv0_ready = 1'b1;
        run_to_end(300, gd, ge, bl, be);
        n = lg_addr.size() - base;
        checks++;
        if (gd !== 1'b1 || n != 7 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL stall_finish done=%b requests=%0d pulses=%0d want 1 7 1", gd, n, done_cnt - d0);
        end
        checks++;
        if (n >= 3 && lg_wdata[base+2] !== 32'hBCC2_0107) begin
            failures++;
            $display("FAIL stall_step2_wdata got=%h want=bcc20107", lg_wdata[base+2]);
        end
    endtask

    task automatic test_poll_retry();
        int base, polls, d0, bl;
        bit gd, ge, be;
        base = lg_addr.size();
        d0 = done_cnt;
        poll_ones = 2;
        pulse_start();
        run_to_end(400, gd, ge, bl, be);
        polls = 0;
        for (int k = base; k < lg_addr.size(); k++) if (lg_rdwrn[k]) polls++;
        checks++;
        if (polls != 3) begin
            failures++;
            $display("FAIL retry_polls got=%0d want=3", polls);
        end
        checks++;
        if (gd !== 1'b1 || done_cnt - d0 != 1 || error !== 1'b0) begin
            failures++;
            $display("FAIL retry_end done=%b pulses=%0d error=%b want 1 1 0", gd, done_cnt - d0, error);
        end
        poll_ones = 0;
    endtask

    task automatic test_poll_timeout();
        int base, polls, d0, bl;
        bit gd, ge, be;
        base = lg_addr.size();
        d0 = done_cnt;
        poll_ones = -1;
        pulse_start();
        run_to_end(400, gd, ge, bl, be);
        polls = 0;
        for (int k = base; k < lg_addr.size(); k++) if (lg_rdwrn[k]) polls++;
        checks++;
        if (polls != 3) begin
            failures++;
            $display("FAIL timeout_polls got=%0d want=3", polls);
        end
        checks++;
        if (ge !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_error seen=%b error=%b busy=%b want 1 1 0", ge, error, busy);
        end
        checks++;
        if (done_cnt - d0 != 0) begin
            failures++;
            $display("FAIL timeout_done_pulses got=%0d want=0", done_cnt - d0);
        end
        poll_ones = 0;
        pulse_start();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_restart error=%b busy=%b want 0 1", error, busy);
        end
        run_to_end(300, gd, ge, bl, be);
        checks++;
        if (gd !== 1'b1) begin
            failures++;
            $display("FAIL timeout_rerun_done got=%b want=1", gd);
        end
    endtask

    task automatic test_back_to_back();
        int base, d0, busy_after;
        bit mid, got;
        base = lg_addr.size();
        d0 = done_cnt;
        mid = 1'b0;
        got = 1'b0;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                start = 1'b1;
                got = 1'b1;
                break;
            end
            if (step == 3'd3 && !mid) begin
                start = 1'b1;
                mid = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        busy_after = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) busy_after++;
        end
        checks++;
        if (!got || !mid || lg_addr.size() - base != 7) begin
            failures++;
            $display("FAIL b2b_sequence done=%b mid_pulse=%b requests=%0d want 1 1 7",
                     got, mid, lg_addr.size() - base);
        end
        checks++;
        if (busy_after != 0 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL b2b_no_rerun busy_cycles=%0d pulses=%0d want 0 1", busy_after, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int base, n, bl;
        bit gd, ge, be, seen;
        seen = 1'b0;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rv1_ready && step == 3'd4) begin
                seen = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!seen || {busy, done, error, rv0_valid, rv1_ready, step} !== 8'd0 ||
            {rv0_addr, rv0_wdata, rv0_wr, rv0_rd, rv0_rd_wrn} !== 44'd0) begin
            failures++;
            $display("FAIL midreset_outputs reached=%b busy=%b rv1_ready=%b step=%0d addr=%h want 1 0 0 0 0",
                     seen, busy, rv1_ready, step, rv0_addr);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        base = lg_addr.size();
        pulse_start();
        run_to_end(300, gd, ge, bl, be);
        n = lg_addr.size() - base;
        checks++;
        if (gd !== 1'b1 || n != 7) begin
            failures++;
            $display("FAIL midreset_rerun done=%b requests=%0d want 1 7", gd, n);
        end
        checks++;
        if (n > 0 && {lg_addr[base], lg_wdata[base]} !== {7'h74, 32'h0000_0001}) begin
            failures++;
            $display("FAIL midreset_first_req addr=%h wdata=%h want 74 00000001",
                     lg_addr[base], lg_wdata[base]);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rv0_ready = 1'b1;
        freq_regs = 48'h01C2_BC01_1EB8;
        test_reset();
        test_sequence();
        test_ready_stall();
        test_poll_retry();
        test_poll_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
